// File: rtl/uart_rx_if.sv
// Receive-side byte interface: the deserializer drives it, the downstream
// consumer (FIR input register / controller) reads it.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output rx_data,
        output data_ready,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input data_ready,
        input frame_err,
        input rx_busy
    );

endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit near its
// centre and presents complete bytes with a one-cycle data_ready strobe.
module uart_rx_deserializer #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic      CLOCK_50,
    input  logic      rst,
    input  logic      UART_RXD,
    uart_rx_if.master rx
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned CntW       = (ClksPerBit > 2) ? $clog2(ClksPerBit) : 1;
    localparam int unsigned IdxW       = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

    localparam logic [CntW-1:0] CntHalf = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHi
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rxs_q;
    logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 frame_err_q, frame_err_d;

    // Synchronizer presets high so a reset never looks like a start bit.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= UART_RXD;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            sh_q         <= '0;
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            sh_q         <= sh_d;
            rx_data_q    <= rx_data_d;
            data_ready_q <= data_ready_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        idx_d        = idx_q;
        sh_d         = sh_q;
        rx_data_d    = rx_data_q;
        data_ready_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d   = StStart;
                    bit_cnt_d = '0;
                end
            end

            // Half a bit in: confirm the start bit, which also aligns all
            // later samples to bit centres.
            StStart: begin
                if (bit_cnt_q == CntHalf) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = rxs_q ? StIdle : StData;
                end else begin
                    bit_cnt_d = bit_cnt_q + CntOne;
                end
            end

            StData: begin
                if (bit_cnt_q == CntFull) begin
                    bit_cnt_d = '0;
                    sh_d      = {rxs_q, sh_q[DATA_BITS-1:1]};
                    idx_d     = idx_q + IdxOne;
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CntOne;
                end
            end

            // Leaving at mid stop bit lets the next start edge be caught
            // even with no idle time between frames.
            StStop: begin
                if (bit_cnt_q == CntFull) begin
                    bit_cnt_d = '0;
                    if (rxs_q) begin
                        rx_data_d    = sh_q;
                        data_ready_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHi;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CntOne;
                end
            end

            // A held-low line (break) must not be mistaken for new frames.
            StWaitHi: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx.rx_data    = rx_data_q;
    assign rx.data_ready = data_ready_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.rx_busy    = (state_q != StIdle);

`ifndef SYNTHESIS
    ready_err_exclusive: assert property (@(posedge CLOCK_50) !(data_ready_q && frame_err_q));
    ready_single_cycle: assert property (@(posedge CLOCK_50) disable iff (rst)
        data_ready_q |=> !data_ready_q);
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomized scoreboard bench for uart_rx_deserializer: expected bytes/errors
// are queued per frame and matched against DUT strobes by an independent monitor.
module tb_uart_rx_deserializer;

    localparam int unsigned CLK_FREQ  = 3_200_000;
    localparam int unsigned BAUD      = 100_000;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned CPB       = CLK_FREQ / BAUD;
    localparam int          HALF      = 50;
    localparam int          BIT_T     = CPB * 2 * HALF;

    typedef struct packed {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic CLOCK_50 = 1'b0;
    logic rst      = 1'b1;
    logic UART_RXD = 1'b1;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) rx_bus ();

    uart_rx_deserializer #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DATA_BITS(DATA_BITS)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .UART_RXD(UART_RXD),
        .rx      (rx_bus)
    );

    always #(HALF) CLOCK_50 = ~CLOCK_50;

    exp_t       exp_q[$];
    int         checks    = 0;
    int         errors    = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_dr   = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: a frame with a high stop bit delivers its byte; a low stop bit
    // reports an error and leaves the last good byte on rx_data.
    task automatic expect_frame(input logic [7:0] d, input bit stop_bit);
        exp_t e;
        if (stop_bit) begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        exp_q.push_back(e);
    endtask

    // Leaves the line at the stop-bit level so callers can chain frames.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int bit_t);
        UART_RXD = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = d[i];
            #(bit_t);
        end
        UART_RXD = stop_bit;
        #(bit_t);
    endtask

    task automatic frame(input logic [7:0] d, input bit stop_bit, input int bit_t);
        expect_frame(d, stop_bit);
        send_frame(d, stop_bit, bit_t);
    endtask

    task automatic idle_bits(input int n);
        UART_RXD = 1'b1;
        #(n * BIT_T);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4 * 11 * CPB) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge CLOCK_50) begin
        exp_t e;
        if (rx_bus.data_ready && rx_bus.frame_err) check("ready_err_overlap", 1, 0);
        if (rx_bus.data_ready && prev_dr) check("data_ready_width", 2, 1);
        if (rx_bus.data_ready || rx_bus.frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {rx_bus.data_ready, rx_bus.frame_err}, 0);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", rx_bus.frame_err, e.is_err);
                check("event_rx_data", rx_bus.rx_data, e.data);
            end
        end
        prev_dr <= rx_bus.data_ready;
    end

    initial begin
        logic [7:0] d;
        bit         stop_bit;
        int         rate;
        int         gap;
        int         n;

        repeat (3) @(negedge CLOCK_50);
        check("reset_rx_data", rx_bus.rx_data, 0);
        check("reset_data_ready", rx_bus.data_ready, 0);
        check("reset_frame_err", rx_bus.frame_err, 0);
        check("reset_rx_busy", rx_bus.rx_busy, 0);
        rst = 1'b0;
        #10;
        idle_bits(2);

        // Single nominal frame.
        frame(8'hA5, 1'b1, BIT_T);
        idle_bits(2);
        drain("drain_a5");
        check("hold_a5", rx_bus.rx_data, 8'hA5);

        // Short low glitch must be rejected.
        UART_RXD = 1'b0;
        #(10 * 2 * HALF);
        UART_RXD = 1'b1;
        n = 0;
        while (rx_bus.rx_busy && n < int'(CPB)) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("glitch_busy_drop", rx_bus.rx_busy, 0);
        #10;
        idle_bits(2);
        check("glitch_rx_data", rx_bus.rx_data, 8'hA5);

        // Bad stop bit followed by a long break: one error only.
        frame(8'h3C, 1'b0, BIT_T);
        #(20 * BIT_T);
        idle_bits(2);
        check("break_rx_data", rx_bus.rx_data, 8'hA5);
        frame(8'h81, 1'b1, BIT_T);
        idle_bits(2);
        drain("drain_81");

        // Back-to-back frames, single stop bit.
        frame(8'h00, 1'b1, BIT_T);
        frame(8'hFF, 1'b1, BIT_T);
        idle_bits(2);
        drain("drain_b2b");

        // Reset during bit 4 of 0x5A discards the frame.
        d = 8'h5A;
        UART_RXD = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            UART_RXD = d[i];
            #(BIT_T);
        end
        UART_RXD = d[4];
        #(BIT_T / 2);
        @(negedge CLOCK_50);
        rst = 1'b1;
        @(negedge CLOCK_50);
        rst       = 1'b0;
        UART_RXD  = 1'b1;
        last_good = 8'h00;
        check("midreset_rx_data", rx_bus.rx_data, 0);
        check("midreset_rx_busy", rx_bus.rx_busy, 0);
        check("midreset_data_ready", rx_bus.data_ready, 0);
        #10;
        idle_bits(2);
        frame(8'h12, 1'b1, BIT_T);
        idle_bits(2);
        drain("drain_12");

        // Baud mismatch of +/-2%.
        frame(8'h55, 1'b1, BIT_T * 102 / 100);
        idle_bits(2);
        frame(8'h55, 1'b1, BIT_T * 98 / 100);
        idle_bits(2);
        drain("drain_tol");

        // Randomized frames, rates, stop bits and gaps.
        for (int k = 0; k < 40; k++) begin
            d        = 8'($urandom);
            stop_bit = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0:       rate = 98;
                1:       rate = 100;
                default: rate = 102;
            endcase
            frame(d, stop_bit, BIT_T * rate / 100);
            gap = stop_bit ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(3);
        drain("drain_random");
        check("final_rx_data", rx_bus.rx_data, last_good);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
